// File: rtl/cic_decimator_param_if.sv
// Bus between the bitstream source and the CIC decimator.
// The master drives the modulator bit, its qualifier and the ratio select.
// The slave returns the decimated word, its strobe and the settled flag.
interface cic_decimator_param_if #(
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic                    bit_in;
  logic [2:0]              ratio_sel;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    settled;

  modport master (
    output in_valid,
    output bit_in,
    output ratio_sel,
    input  out_data,
    input  out_valid,
    input  settled
  );

  modport slave (
    input  in_valid,
    input  bit_in,
    input  ratio_sel,
    output out_data,
    output out_valid,
    output settled
  );
endinterface

// File: rtl/cic_decimator_param.sv
// N-stage CIC decimator for a 1-bit delta-sigma bitstream with a runtime ratio.
//
// Everything runs on the single system clock. in_valid marks the cycles that carry
// a modulator sample. Decimation is done by an internal sample counter.
//
// The integrators run on every qualified sample. The combs run only on decimation
// events. The comb output is scaled to the same full scale at every ratio, then
// truncated (floor) and saturated into the OUT_W output word.
//
// A change of the clamped ratio select clears the filter state synchronously and
// restarts the warm-up. The first ORDER decimation events after a clear only prime
// the combs.
module cic_decimator_param #(
  parameter int ORDER     = 3,
  parameter int LOG2_RMAX = 6,
  parameter int OUT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cic_decimator_param_if.slave  bus
);

  localparam int ACC_W  = ORDER * LOG2_RMAX + 2;
  // Right shift that maps the normalised full scale 2**(ORDER*LOG2_RMAX) onto 2**(OUT_W-1).
  localparam int SHR    = ACC_W - 1 - OUT_W;
  // Headroom so the normalising left shift can never wrap, even on warm-up garbage.
  localparam int WIDE_W = ACC_W + ORDER * LOG2_RMAX;
  localparam int WARM_W = (ORDER < 2) ? 1 : $clog2(ORDER + 1);

  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);

  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    signed'({{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    signed'({{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  typedef logic [ORDER-1:0][ACC_W-1:0] stage_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Map a raw ratio select onto the legal range 1..LOG2_RMAX.
  function automatic logic [2:0] clamp_ratio_f(input logic [2:0] sel);
    logic [2:0] r;
    if (sel == 3'd0) begin
      r = 3'd1;
    end else if (int'(sel) > LOG2_RMAX) begin
      r = 3'(LOG2_RMAX);
    end else begin
      r = sel;
    end
    return r;
  endfunction

  // Terminal count of the sample counter, R-1 = 2**ratio - 1.
  function automatic logic [LOG2_RMAX-1:0] last_count_f(input logic [2:0] ratio);
    logic [LOG2_RMAX-1:0] m;
    for (int i = 0; i < LOG2_RMAX; i++) begin
      m[i] = (i < int'(ratio));
    end
    return m;
  endfunction

  // One integrator update. Each stage adds the already-updated value of the
  // stage before it, so the whole cascade settles in a single cycle.
  function automatic stage_t integrate_f(input stage_t acc, input logic b);
    stage_t             nxt;
    logic [ACC_W-1:0]   carry;
    carry = b ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    for (int k = 0; k < ORDER; k++) begin
      nxt[k] = acc[k] + carry;
      carry  = nxt[k];
    end
    return nxt;
  endfunction

  // New comb delay contents. Each delay captures the input of its own stage.
  function automatic stage_t comb_delay_f(input logic [ACC_W-1:0] c0, input stage_t dly);
    stage_t           nd;
    logic [ACC_W-1:0] c;
    c = c0;
    for (int k = 0; k < ORDER; k++) begin
      nd[k] = c;
      c     = c - dly[k];
    end
    return nd;
  endfunction

  // Comb cascade output y = C_N for a decimation event.
  function automatic logic [ACC_W-1:0] comb_out_f(input logic [ACC_W-1:0] c0, input stage_t dly);
    logic [ACC_W-1:0] c;
    c = c0;
    for (int k = 0; k < ORDER; k++) begin
      c = c - dly[k];
    end
    return c;
  endfunction

  // Scale y to the fixed full scale, floor-truncate and saturate to OUT_W bits.
  function automatic logic [OUT_W-1:0] normalise_f(input logic [ACC_W-1:0] y,
                                                   input logic [2:0]       ratio);
    logic signed [WIDE_W-1:0] w;
    logic [OUT_W-1:0]         r;
    int                       sh;
    sh = ORDER * (LOG2_RMAX - int'(ratio));
    w  = signed'({{(WIDE_W-ACC_W){y[ACC_W-1]}}, y});
    w  = w <<< sh;
    w  = w >>> SHR;
    if (w > SAT_MAX) begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w < SAT_MIN) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = w[OUT_W-1:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  stage_t                  integ_r;
  stage_t                  dly_r;
  logic [LOG2_RMAX-1:0]    cnt_r;
  logic [WARM_W-1:0]       warm_r;
  logic [2:0]              ratio_r;
  // Low only between reset release and the first clock. Until then the active
  // ratio simply follows the clamped select, so no clear is triggered.
  logic                    ratio_loaded_r;
  logic signed [OUT_W-1:0] out_data_r;
  logic                    out_valid_r;
  logic                    settled_r;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [2:0]       sel_clamped_s;
  logic [2:0]       active_ratio_s;
  logic             ratio_change_s;
  logic             cnt_last_s;
  logic             dec_event_s;
  logic             warm_done_s;
  stage_t           integ_next_s;
  stage_t           comb_dly_next_s;
  logic [ACC_W-1:0] comb_y_s;
  logic [OUT_W-1:0] norm_s;

  // Ratio bookkeeping, event detection and the filter arithmetic for this cycle.
  always_comb begin
    sel_clamped_s = clamp_ratio_f(bus.ratio_sel);

    if (ratio_loaded_r) begin
      active_ratio_s = ratio_r;
      ratio_change_s = (sel_clamped_s != ratio_r);
    end else begin
      active_ratio_s = sel_clamped_s;
      ratio_change_s = 1'b0;
    end

    cnt_last_s  = (cnt_r == last_count_f(active_ratio_s));
    dec_event_s = bus.in_valid & cnt_last_s & ~ratio_change_s;
    warm_done_s = (warm_r == WARM_DONE);

    integ_next_s    = integrate_f(integ_r, bus.bit_in);
    comb_dly_next_s = comb_delay_f(integ_next_s[ORDER-1], dly_r);
    comb_y_s        = comb_out_f(integ_next_s[ORDER-1], dly_r);
    norm_s          = normalise_f(comb_y_s, active_ratio_s);
  end

  // Integrators, comb delays, sample and warm-up counters and the latched ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_r        <= '0;
      dly_r          <= '0;
      cnt_r          <= '0;
      warm_r         <= '0;
      ratio_r        <= 3'd1;
      ratio_loaded_r <= 1'b0;
    end else if (ratio_change_s) begin
      integ_r        <= '0;
      dly_r          <= '0;
      cnt_r          <= '0;
      warm_r         <= '0;
      ratio_r        <= sel_clamped_s;
      ratio_loaded_r <= 1'b1;
    end else begin
      ratio_r        <= active_ratio_s;
      ratio_loaded_r <= 1'b1;
      if (bus.in_valid) begin
        integ_r <= integ_next_s;
        if (dec_event_s) begin
          cnt_r <= '0;
          dly_r <= comb_dly_next_s;
          if (!warm_done_s) begin
            warm_r <= warm_r + WARM_W'(1);
          end else begin
            warm_r <= warm_r;
          end
        end else begin
          cnt_r  <= cnt_r + LOG2_RMAX'(1);
          dly_r  <= dly_r;
          warm_r <= warm_r;
        end
      end else begin
        integ_r <= integ_r;
        dly_r   <= dly_r;
        cnt_r   <= cnt_r;
        warm_r  <= warm_r;
      end
    end
  end

  // Output word, strobe and settled flag. A post-warm-up event publishes a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      settled_r   <= 1'b0;
    end else if (ratio_change_s) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      settled_r   <= 1'b0;
    end else if (dec_event_s && warm_done_s) begin
      out_data_r  <= signed'(norm_s);
      out_valid_r <= 1'b1;
      settled_r   <= 1'b1;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      settled_r   <= settled_r;
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.settled   = settled_r;

endmodule

// File: tb/tb_cic_decimator_param.sv
// Self-checking bench for cic_decimator_param.
// The reference model treats the decimator as an FIR filter. Its taps are the
// ORDER-fold convolution of a length-R boxcar, applied to the bipolar samples
// received since the last clear (zeros before that). The model emits a sample
// on every R-th qualified input once ORDER warm-up events have passed.
module tb_cic_decimator_param;

  localparam int ORDER     = 3;
  localparam int LOG2_RMAX = 6;
  localparam int OUT_W     = 16;
  localparam int SHR       = ORDER * LOG2_RMAX + 2 - 1 - OUT_W;
  localparam int OMAX      = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN      = -(1 << (OUT_W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cic_decimator_param_if #(.OUT_W(OUT_W)) bus ();

  cic_decimator_param #(
    .ORDER     (ORDER),
    .LOG2_RMAX (LOG2_RMAX),
    .OUT_W     (OUT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ratio;
  int m_r;
  int h[$];
  bit hist[$];        // newest sample at index 0
  int nvalid;
  int exp_data;
  bit exp_valid;
  bit exp_settled;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, $signed(obs), $signed(exp), $time);
    end
  endtask

  function automatic int clamp_sel(input int s);
    if (s == 0) return 1;
    if (s > LOG2_RMAX) return LOG2_RMAX;
    return s;
  endfunction

  task automatic model_clear(input int ratio);
    int cur[$];
    int nxt[$];
    int acc;
    m_ratio = ratio;
    m_r     = 1 << ratio;
    hist.delete();
    nvalid  = 0;
    cur.delete();
    cur.push_back(1);
    repeat (ORDER) begin
      nxt.delete();
      for (int i = 0; i < cur.size() + m_r - 1; i++) begin
        acc = 0;
        for (int j = 0; j < m_r; j++) begin
          if (i - j >= 0 && i - j < cur.size()) acc += cur[i - j];
        end
        nxt.push_back(acc);
      end
      cur = nxt;
    end
    h = cur;
  endtask

  function automatic int model_output();
    longint y;
    longint yn;
    y = 0;
    for (int j = 0; j < h.size(); j++) begin
      if (j < hist.size()) y += longint'(h[j]) * (hist[j] ? 64'sd1 : -64'sd1);
    end
    yn = y <<< (ORDER * (LOG2_RMAX - m_ratio));
    yn = yn >>> SHR;
    if (yn > OMAX) return OMAX;
    if (yn < OMIN) return OMIN;
    return int'(yn);
  endfunction

  // One clock: drive inputs, advance the model, compare all three outputs.
  task automatic step(input bit v, input bit b, input int s);
    @(negedge clk);
    bus.in_valid  = v;
    bus.bit_in    = b;
    bus.ratio_sel = 3'(s);
    @(posedge clk);
    #1;
    if (clamp_sel(s) != m_ratio) begin
      model_clear(clamp_sel(s));
      exp_valid   = 1'b0;
      exp_settled = 1'b0;
    end else if (v) begin
      hist.push_front(b);
      if (hist.size() > ORDER * m_r) void'(hist.pop_back());
      nvalid++;
      if ((nvalid % m_r) == 0 && (nvalid / m_r) > ORDER) begin
        exp_valid   = 1'b1;
        exp_settled = 1'b1;
        exp_data    = model_output();
      end else begin
        exp_valid = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    check_val("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check_val("settled", 32'(bus.settled), 32'(exp_settled));
    check_val("out_data", 32'($signed(bus.out_data)), exp_data);
  endtask

  // Assert reset asynchronously in mid-cycle and hold it for a few edges.
  task automatic apply_reset(input int s, input int hold);
    @(negedge clk);
    bus.ratio_sel = 3'(s);
    bus.in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_settled", 32'(bus.settled), 32'd0);
    check_val("rst_out_data", 32'($signed(bus.out_data)), 32'd0);
    model_clear(clamp_sel(s));
    exp_valid   = 1'b0;
    exp_settled = 1'b0;
    exp_data    = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sel;
    int bias;
    bus.in_valid  = 1'b0;
    bus.bit_in    = 1'b0;
    bus.ratio_sel = 3'd6;
    exp_data      = 0;
    exp_valid     = 1'b0;
    exp_settled   = 1'b0;
    model_clear(6);

    // Constant +1 input at R=64: first strobe after 256 valid samples, saturated.
    apply_reset(6, 2);
    for (int i = 1; i <= 320; i++) begin
      step(1'b1, 1'b1, 6);
      if (i == 255) check_val("t1_no_early", 32'(bus.out_valid), 32'd0);
      if (i == 256) begin
        check_val("t1_first_strobe", 32'(bus.out_valid), 32'd1);
        check_val("t1_sat_pos", 32'($signed(bus.out_data)), 32'h0000_7FFF);
        check_val("t1_settled", 32'(bus.settled), 32'd1);
      end
      if (i == 319) check_val("t1_gap", 32'(bus.out_valid), 32'd0);
      if (i == 320) check_val("t1_cadence", 32'(bus.out_valid), 32'd1);
    end

    // Constant -1 input: negative full scale.
    for (int i = 1; i <= 320; i++) begin
      step(1'b1, 1'b0, 6);
      if (i == 320) check_val("t2_sat_neg", 32'($signed(bus.out_data)), 32'hFFFF_8000);
    end

    // Alternating input: null at fs/2.
    for (int i = 1; i <= 320; i++) begin
      step(1'b1, i[0], 6);
      if (i == 320) check_val("t3_null", 32'($signed(bus.out_data)), 32'd0);
    end

    // Ratio change 6 -> 2 mid-frame.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 6);
    step(1'b1, 1'b1, 2);
    check_val("t4_settled_drop", 32'(bus.settled), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 2);
      if (i == 15) check_val("t4_no_early", 32'(bus.out_valid), 32'd0);
      if (i == 16) begin
        check_val("t4_first_strobe", 32'(bus.out_valid), 32'd1);
        check_val("t4_sat_pos", 32'($signed(bus.out_data)), 32'h0000_7FFF);
      end
      if (i == 20) check_val("t4_cadence", 32'(bus.out_valid), 32'd1);
    end

    // Sparse qualifier at R=8, random bits.
    for (int i = 0; i < 300; i++) begin
      step((i % 3) == 0, 1'($urandom_range(0, 1)), 3);
    end

    // Mid-frame reset with an out-of-range select.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 3);
    apply_reset(7, 3);
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 1'b1, 7);
      if (i == 255) check_val("t6_no_early", 32'(bus.out_valid), 32'd0);
      if (i == 256) begin
        check_val("t6_first_strobe", 32'(bus.out_valid), 32'd1);
        check_val("t6_sat_pos", 32'($signed(bus.out_data)), 32'h0000_7FFF);
      end
    end

    // Randomised traffic: biased bits, random qualifier, occasional ratio changes and resets.
    sel  = 7;
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 0) bias = int'($urandom_range(0, 100));
      if ($urandom_range(0, 399) == 0) sel = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1499) == 0) apply_reset(sel, 2);
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 99)) < bias, sel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
